// File: rtl/multiplier_accum.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_accum
// Purpose  : Sums N_SAMPLES 32-bit product beats (modulo 2^32) taken over a
//            valid/ready input, then presents the block sum on a valid/ready
//            output and holds it until the sink accepts it.
// Ports    : clk, rst (async, active-high)
//            i_data0/i_valid/o_ready  - product beat input handshake
//            i_clear                  - synchronous abort of the open block
//            o_data0/o_valid/i_ready  - block sum output handshake
//            o_count                  - beats accumulated in the open block
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_accum #(
    parameter int N_SAMPLES = 8,
    parameter int CW        = $clog2(N_SAMPLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   i_data0,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_clear,
    output logic [31:0]   o_data0,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [CW-1:0] o_count
);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_LAST = CW'(N_SAMPLES - 1);

    state_t        state_q, state_d;
    logic [31:0]   acc_q,   acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   data_q,  data_d;
    logic          valid_q, valid_d;

    logic          w_take;
    logic [31:0]   w_sum;

    // Ready is suppressed while reset is asserted so a beat can never be
    // presented as accepted to the upstream block during reset.
    assign o_ready = (state_q == ACC) & ~rst & ~i_clear;
    assign w_take  = i_valid & o_ready;
    assign w_sum   = acc_q + i_data0;   // carry intentionally discarded

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (i_clear) begin
            // Abort: open block and any pending result are dropped;
            // o_data0 keeps its last (now meaningless) value.
            state_d = ACC;
            acc_d   = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (w_take) begin
                        if (count_q == C_LAST) begin
                            data_d  = w_sum;
                            valid_d = 1'b1;
                            acc_d   = '0;
                            count_d = '0;
                            state_d = HOLD;
                        end else begin
                            acc_d   = w_sum;
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // No bypass: the first beat of the next block is taken
                    // no earlier than the cycle after the transfer.
                    if (i_ready) begin
                        valid_d = 1'b0;
                        state_d = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data0 = data_q;
    assign o_valid = valid_q;
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_accum
// Purpose  : Directed self-checking bench for multiplier_accum, exercising an
//            N_SAMPLES=8 instance and an N_SAMPLES=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_accum;

    logic        clk;
    logic        rst;

    // N_SAMPLES = 8 instance
    logic [31:0] data;
    logic        valid;
    logic        rdy;
    logic        clear;
    logic [31:0] od;
    logic        ov;
    logic        iready;
    logic [3:0]  cnt;

    // N_SAMPLES = 1 instance
    logic [31:0] d1;
    logic        v1;
    logic        rdy1;
    logic        c1;
    logic [31:0] od1;
    logic        ov1;
    logic        r1;
    logic [0:0]  cnt1;

    int checks;
    int errors;

    multiplier_accum #(.N_SAMPLES(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .i_data0 (data),
        .i_valid (valid),
        .o_ready (rdy),
        .i_clear (clear),
        .o_data0 (od),
        .o_valid (ov),
        .i_ready (iready),
        .o_count (cnt)
    );

    multiplier_accum #(.N_SAMPLES(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .i_data0 (d1),
        .i_valid (v1),
        .o_ready (rdy1),
        .i_clear (c1),
        .o_data0 (od1),
        .o_valid (ov1),
        .i_ready (r1),
        .o_count (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive n back-to-back beats of value d into the N_SAMPLES=8 instance.
    task automatic run_block(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            data  = d;
            #0;
            check("blk_ready", {31'b0, rdy}, 32'd1);
            step();
        end
        valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        data   = '0;
        valid  = 1'b0;
        clear  = 1'b0;
        iready = 1'b1;
        d1     = '0;
        v1     = 1'b0;
        c1     = 1'b0;
        r1     = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check("rst_valid", {31'b0, ov}, 32'd0);
        check("rst_count", {28'b0, cnt}, 32'd0);
        check("rst_data",  od, 32'd0);
        check("rst_ready", {31'b0, rdy}, 32'd0);
        #11;
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, rdy}, 32'd1);

        // ---------------- basic block ----------------
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            data  = 32'd24465;
            #0;
            check("basic_count", {28'b0, cnt}, i);
            check("basic_nvalid", {31'b0, ov}, 32'd0);
            step();
        end
        valid = 1'b0;
        check("basic_valid", {31'b0, ov}, 32'd1);
        check("basic_sum",   od, 32'd195720);
        check("basic_hold_ready", {31'b0, rdy}, 32'd0);
        check("basic_count_wrap", {28'b0, cnt}, 32'd0);
        step();
        check("basic_ack_valid", {31'b0, ov}, 32'd0);
        check("basic_ack_ready", {31'b0, rdy}, 32'd1);

        // ---------------- wrap-around ----------------
        run_block(32'h8000_0000, 8);
        check("wrap1_valid", {31'b0, ov}, 32'd1);
        check("wrap1_sum", od, 32'h0000_0000);
        step();
        run_block(32'hFFFF_FFFF, 8);
        check("wrap2_valid", {31'b0, ov}, 32'd1);
        check("wrap2_sum", od, 32'hFFFF_FFF8);
        step();

        // ---------------- backpressure ----------------
        iready = 1'b0;
        run_block(32'd1, 8);
        valid = 1'b1;
        data  = 32'd7;
        for (int i = 0; i < 5; i++) begin
            #0;
            check("bp_valid", {31'b0, ov}, 32'd1);
            check("bp_data", od, 32'd8);
            check("bp_ready", {31'b0, rdy}, 32'd0);
            step();
        end
        iready = 1'b1;
        step();
        valid = 1'b0;
        check("bp_ack_valid", {31'b0, ov}, 32'd0);
        check("bp_ack_count", {28'b0, cnt}, 32'd0);
        run_block(32'd7, 8);
        check("bp_fresh_sum", od, 32'd56);
        check("bp_fresh_valid", {31'b0, ov}, 32'd1);
        step();

        // ---------------- clear ----------------
        run_block(32'd100, 3);
        check("clr_count_pre", {28'b0, cnt}, 32'd3);
        clear = 1'b1;
        valid = 1'b1;
        data  = 32'd999;
        #0;
        check("clr_ready", {31'b0, rdy}, 32'd0);
        step();
        clear = 1'b0;
        valid = 1'b0;
        check("clr_count", {28'b0, cnt}, 32'd0);
        run_block(32'd1, 8);
        check("clr_sum", od, 32'd8);
        check("clr_valid", {31'b0, ov}, 32'd1);
        iready = 1'b0;
        clear  = 1'b1;
        step();
        clear = 1'b0;
        #0;
        check("clr_hold_valid", {31'b0, ov}, 32'd0);
        check("clr_hold_ready", {31'b0, rdy}, 32'd1);
        iready = 1'b1;

        // ---------------- reset mid-operation ----------------
        run_block(32'd3, 5);
        check("mrst_count_pre", {28'b0, cnt}, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_valid", {31'b0, ov}, 32'd0);
        check("mrst_count", {28'b0, cnt}, 32'd0);
        check("mrst_data", od, 32'd0);
        check("mrst_ready", {31'b0, rdy}, 32'd0);
        rst = 1'b0;
        step();
        run_block(32'd2, 8);
        check("mrst_sum", od, 32'd16);
        iready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("hrst_valid", {31'b0, ov}, 32'd0);
        check("hrst_data", od, 32'd0);
        check("hrst_ready", {31'b0, rdy}, 32'd0);
        check("hrst_count", {28'b0, cnt}, 32'd0);
        rst = 1'b0;
        iready = 1'b1;
        step();
        run_block(32'd2, 8);
        check("hrst_sum", od, 32'd16);
        check("hrst_sum_valid", {31'b0, ov}, 32'd1);
        step();

        // ---------------- N_SAMPLES = 1 ----------------
        r1 = 1'b0;
        v1 = 1'b1;
        d1 = 32'd5;
        #0;
        check("n1_ready0", {31'b0, rdy1}, 32'd1);
        step();
        check("n1_valid5", {31'b0, ov1}, 32'd1);
        check("n1_data5", od1, 32'd5);
        check("n1_ready5", {31'b0, rdy1}, 32'd0);
        check("n1_count", {31'b0, cnt1}, 32'd0);
        d1 = 32'd6;
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        check("n1_ack5_valid", {31'b0, ov1}, 32'd0);
        check("n1_ack5_ready", {31'b0, rdy1}, 32'd1);
        step();
        check("n1_data6", od1, 32'd6);
        check("n1_valid6", {31'b0, ov1}, 32'd1);
        check("n1_ready6", {31'b0, rdy1}, 32'd0);
        d1 = 32'd7;
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        check("n1_ack6_ready", {31'b0, rdy1}, 32'd1);
        step();
        v1 = 1'b0;
        check("n1_data7", od1, 32'd7);
        check("n1_valid7", {31'b0, ov1}, 32'd1);
        check("n1_ready7", {31'b0, rdy1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplier_accum.md
# multiplier_accum

Accumulating consumer placed directly downstream of the constant-multiplier block. It accepts one 32-bit product per beat over a valid/ready handshake and sums `N_SAMPLES` beats modulo 2^32, the same wrap-around arithmetic the multiplier uses. It then presents the block sum on a valid/ready output and holds it until the sink accepts it.

## Interface
Parameters:
- `N_SAMPLES`, default 8: beats per block; legal range is 1 or more.
- `CW`, default `$clog2(N_SAMPLES+1)`: width of `o_count`; derived, never overridden.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `i_data0`  input  32  product beat from the multiplier, unsigned.
- `i_valid`  input  1  `i_data0` is valid this cycle.
- `o_ready`  output  1  block accepts a beat this cycle; beat is taken when `i_valid & o_ready`.
- `i_clear`  input  1  synchronous abort of the current block.
- `o_data0`  output  32  block sum, valid while `o_valid` is high.
- `o_valid`  output  1  block sum available.
- `i_ready`  input  1  sink accepts; transfer happens when `o_valid & i_ready`.
- `o_count`  output  CW  beats accumulated in the open block.

## Operation
- There are two states: ACC and HOLD.
- `o_ready` is combinational: `(state==ACC) & ~rst & ~i_clear`.
- In ACC, an accepted beat with `o_count < N_SAMPLES-1` does the following:
  - `acc <= acc + i_data0`, truncated to 32 bits with the carry discarded;
  - `o_count <= o_count + 1`.
- In ACC, an accepted beat with `o_count == N_SAMPLES-1` does the following:
  - `o_data0 <= acc + i_data0`, truncated;
  - `o_valid <= 1`;
  - `acc <= 0` and `o_count <= 0`;
  - state moves to HOLD.
- In ACC with no accepted beat, all state holds.
- In HOLD:
  - `o_ready = 0`;
  - `o_data0` and `o_valid` are held stable;
  - on `i_ready`, `o_valid <= 0` and state moves to ACC.
- There is no bypass: a beat is never accepted in the cycle the output transfers.
- `i_clear` has the highest priority after reset. When high at a clock edge:
  - `acc` and `o_count` go to 0, `o_valid` goes to 0, state goes to ACC;
  - any `i_valid` beat that cycle is not accepted, because `o_ready` is 0;
  - a pending HOLD result is discarded.
- `N_SAMPLES == 1`: every accepted beat goes straight to HOLD with `o_data0` equal to that beat.
- `o_data0` keeps its last value after a transfer or clear; it is meaningful only while `o_valid` is high.

## Timing
- While `rst` is high, asynchronously:
  - state = ACC, `acc` = 0, `o_count` = 0;
  - `o_data0` = 0, `o_valid` = 0, `o_ready` = 0.
- `o_ready` may first go high in the cycle `rst` is low.
- Latency: `o_valid` rises on the clock edge that accepts the `N_SAMPLES`-th beat, so it is visible the next cycle.
- Peak throughput is one block per `N_SAMPLES+1` cycles when `i_ready` is held high.
- Reset mid-block or mid-HOLD: all partial sums and pending results are lost, and outputs take their reset values immediately.
- `o_count` ranges from 0 to `N_SAMPLES-1`. It never shows `N_SAMPLES`, because it clears on the completing beat.

## Test plan
- **Basic block.** `N_SAMPLES=8`, `i_ready=1`, eight back-to-back beats of 24465 (product for input 1).
  - `o_valid` is high for one cycle with `o_data0 = 195720`.
  - `o_ready` is 0 in that cycle.
  - `o_count` sequence is 0..7, then 0.
- **Wrap-around.** Eight beats of `0x80000000`, then eight beats of `0xFFFFFFFF`.
  - `o_data0 = 0x00000000`, then `o_data0 = 0xFFFFFFF8`.
- **Backpressure.** Complete a block of eight beats of 1, then hold `i_ready=0` for 5 cycles while `i_valid=1` with data 7.
  - `o_data0 = 8` stays stable and `o_ready = 0` throughout.
  - After `i_ready` rises, the next accepted beats start a fresh sum.
- **Clear.** Three beats of 100, then `i_clear` with `i_valid=1` and data 999, then eight beats of 1.
  - The 999 beat is not accepted and `o_count` returns to 0.
  - Result is `o_data0 = 8`.
  - A second run asserts `i_clear` during HOLD: `o_valid` drops next cycle with no transfer.
- **Reset mid-operation.** Assert `rst` asynchronously between edges, once after 5 beats and once during HOLD.
  - `o_valid`, `o_count`, `o_data0` and `o_ready` go to 0 without a clock edge.
  - After release, eight beats of 2 give 16.
- **N_SAMPLES=1 build.** Beats 5, 6, 7 with `i_ready` toggling.
  - Each beat produces its own `o_data0` (5, 6, 7).
  - `o_ready` alternates with `o_valid`.
